// File: rtl/draw_pkg.sv
// Shared definitions for the draw sequencer: screen/sprite geometry, the
// sequencer state encoding and small combinational helpers.
package draw_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int SPR_W    = 12;
    localparam int SPR_H    = 16;

    // Largest top-left sprite corner that keeps the whole sprite on screen.
    localparam logic [7:0] MAX_X = 8'(SCREEN_W - SPR_W);
    localparam logic [7:0] MAX_Y = 8'(SCREEN_H - SPR_H);

    localparam int WDOG_W = 15;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_STAGE = 3'd1,
        S_ERASE = 3'd2,
        S_GAP   = 3'd3,
        S_DRAW  = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    // Unsigned saturation of a coordinate to its legal maximum.
    function automatic logic [7:0] clamp8(input logic [7:0] v, input logic [7:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    // States in which an engine command is being held.
    function automatic logic is_cmd(input state_t s);
        return (s == S_STAGE) || (s == S_ERASE) || (s == S_DRAW);
    endfunction

endpackage

// File: rtl/draw_sequencer_plot_mux.sv
// VGA plot bus mux: delays the "command active" condition by one cycle to line
// up with the engine's registered pixel coordinates, and selects the sprite or
// background coordinate source.
module plot_mux
    import draw_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  state_t     state,
    input  logic       draw_done,
    input  logic [7:0] mario_x,
    input  logic [7:0] mario_y,
    input  logic [7:0] bkg_x,
    input  logic [7:0] bkg_y,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic       plot,
    output logic       colour_sel
);

    logic plot_d, plot_q;
    logic sel_d,  sel_q;

    // Next plot/select: plot while a command runs, except on its final (done) cycle.
    always_comb begin
        plot_d = 1'b0;
        sel_d  = 1'b0;
        if (is_cmd(state) && !draw_done) begin
            plot_d = 1'b1;
        end else begin
            plot_d = 1'b0;
        end
        if (state == S_DRAW) begin
            sel_d = 1'b1;
        end else begin
            sel_d = 1'b0;
        end
    end

    // One-cycle delay register for plot enable and colour source.
    always_ff @(posedge clk) begin
        if (reset) begin
            plot_q <= 1'b0;
            sel_q  <= 1'b0;
        end else begin
            plot_q <= plot_d;
            sel_q  <= sel_d;
        end
    end

    // Coordinate source select; y bus carries only the low 7 bits.
    always_comb begin
        vga_x = bkg_x;
        vga_y = bkg_y[6:0];
        if (sel_q) begin
            vga_x = mario_x;
            vga_y = mario_y[6:0];
        end else begin
            vga_x = bkg_x;
            vga_y = bkg_y[6:0];
        end
    end

    assign plot       = plot_q;
    assign colour_sel = sel_q;

endmodule

// File: rtl/draw_sequencer.sv
// Draw engine scheduler: sequences stage/erase/draw commands one at a time,
// latches the clamped sprite position, tracks pending requests and aborts a
// command that never completes.
module draw_sequencer
    import draw_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 20000,
    parameter logic [7:0] MAX_X_P        = MAX_X,
    parameter logic [7:0] MAX_Y_P        = MAX_Y
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       stage_req,
    input  logic [7:0] pos_x,
    input  logic [7:0] pos_y,
    input  logic       draw_done,
    input  logic [7:0] mario_x,
    input  logic [7:0] mario_y,
    input  logic [7:0] bkg_x,
    input  logic [7:0] bkg_y,
    output logic       drM,
    output logic       erM,
    output logic       drStage1,
    output logic [7:0] px,
    output logic [7:0] py,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic       plot,
    output logic       colour_sel,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun,
    output logic       timeout_err
);

    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYCLES - 1);

    state_t            state_d, state_q;
    logic [7:0]        px_d, px_q, py_d, py_q;
    logic [7:0]        nxt_x_d, nxt_x_q, nxt_y_d, nxt_y_q;
    logic              stage_pend_d, stage_pend_q;
    logic              draw_pend_d, draw_pend_q;
    logic              boot_d, boot_q;
    logic [WDOG_W-1:0] wdog_d, wdog_q;
    logic              timeout_err_d, timeout_err_q;
    logic              overrun_d, overrun_q;
    logic [7:0]        clamp_x_s, clamp_y_s;

    assign clamp_x_s = clamp8(pos_x, MAX_X_P);
    assign clamp_y_s = clamp8(pos_y, MAX_Y_P);

    // Next-state, position latch, pending flags and watchdog.
    always_comb begin
        state_d       = state_q;
        px_d          = px_q;
        py_d          = py_q;
        nxt_x_d       = nxt_x_q;
        nxt_y_d       = nxt_y_q;
        stage_pend_d  = stage_pend_q;
        draw_pend_d   = draw_pend_q;
        boot_d        = boot_q;
        wdog_d        = '0;
        timeout_err_d = timeout_err_q;
        overrun_d     = 1'b0;

        // Requests arriving while busy: stage is remembered, frame tick is dropped.
        if (state_q != S_IDLE) begin
            stage_pend_d = stage_pend_q | stage_req;
            overrun_d    = frame_tick;
        end else begin
            overrun_d    = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (stage_req || stage_pend_q || boot_q) begin
                    state_d      = S_STAGE;
                    stage_pend_d = 1'b0;
                    boot_d       = 1'b0;
                    draw_pend_d  = 1'b1;
                end else if (frame_tick && ((clamp_x_s != px_q) || (clamp_y_s != py_q))) begin
                    state_d     = S_ERASE;
                    nxt_x_d     = clamp_x_s;
                    nxt_y_d     = clamp_y_s;
                    draw_pend_d = 1'b1;
                end else if (frame_tick) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_STAGE, S_ERASE: begin
                if (draw_done) begin
                    state_d = S_GAP;
                    px_d    = nxt_x_q;
                    py_d    = nxt_y_q;
                end else if (wdog_q == WDOG_LIMIT) begin
                    state_d       = S_IDLE;
                    timeout_err_d = 1'b1;
                    draw_pend_d   = 1'b0;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            S_GAP: begin
                // Single quiet cycle so the engine counters rearm.
                if (draw_pend_q) begin
                    state_d = S_DRAW;
                end else begin
                    state_d = S_FIN;
                end
            end
            S_DRAW: begin
                if (draw_done) begin
                    state_d     = S_FIN;
                    draw_pend_d = 1'b0;
                end else if (wdog_q == WDOG_LIMIT) begin
                    state_d       = S_IDLE;
                    timeout_err_d = 1'b1;
                    draw_pend_d   = 1'b0;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset forces a power-up stage redraw.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            px_q          <= 8'd0;
            py_q          <= 8'd0;
            nxt_x_q       <= 8'd0;
            nxt_y_q       <= 8'd0;
            stage_pend_q  <= 1'b0;
            draw_pend_q   <= 1'b0;
            boot_q        <= 1'b1;
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            px_q          <= px_d;
            py_q          <= py_d;
            nxt_x_q       <= nxt_x_d;
            nxt_y_q       <= nxt_y_d;
            stage_pend_q  <= stage_pend_d;
            draw_pend_q   <= draw_pend_d;
            boot_q        <= boot_d;
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign drStage1    = (state_q == S_STAGE);
    assign erM         = (state_q == S_ERASE);
    assign drM         = (state_q == S_DRAW);
    assign busy        = (state_q != S_IDLE);
    assign frame_done  = (state_q == S_FIN);
    assign px          = px_q;
    assign py          = py_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_err_q;

    plot_mux u_plot_mux (
        .clk        (clk),
        .reset      (reset),
        .state      (state_q),
        .draw_done  (draw_done),
        .mario_x    (mario_x),
        .mario_y    (mario_y),
        .bkg_x      (bkg_x),
        .bkg_y      (bkg_y),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .plot       (plot),
        .colour_sel (colour_sel)
    );

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer with a hand-driven engine done stub.
module tb_draw_sequencer;

    localparam int TMO = 20000;

    logic       clk = 1'b0;
    logic       reset, frame_tick, stage_req, draw_done;
    logic [7:0] pos_x, pos_y, mario_x, mario_y, bkg_x, bkg_y;
    logic       drM, erM, drStage1;
    logic [7:0] px, py, vga_x;
    logic [6:0] vga_y;
    logic       plot, colour_sel, busy, frame_done, overrun, timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    int bad      = 0;

    always #5 clk = ~clk;

    draw_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .stage_req(stage_req),
        .pos_x(pos_x), .pos_y(pos_y), .draw_done(draw_done),
        .mario_x(mario_x), .mario_y(mario_y), .bkg_x(bkg_x), .bkg_y(bkg_y),
        .drM(drM), .erM(erM), .drStage1(drStage1), .px(px), .py(py),
        .vga_x(vga_x), .vga_y(vga_y), .plot(plot), .colour_sel(colour_sel),
        .busy(busy), .frame_done(frame_done), .overrun(overrun), .timeout_err(timeout_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done();
        draw_done = 1'b1;
        step();
        draw_done = 1'b0;
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; stage_req = 1'b0; draw_done = 1'b0;
        pos_x = 8'd0; pos_y = 8'd0;
        mario_x = 8'hAA; mario_y = 8'hC3; bkg_x = 8'h55; bkg_y = 8'h3C;
        repeat (3) step();

        // Reset state
        check_eq("rst_cmds", {drStage1, erM, drM}, 3'b000);
        check_eq("rst_pos", {px, py}, 16'h0000);
        check_eq("rst_misc", {plot, colour_sel, busy, frame_done, overrun, timeout_err}, 6'b0);

        // 1: power-up stage draw
        reset = 1'b0;
        step();
        check_eq("t1_stage_on", {drStage1, erM, drM, busy}, 4'b1001);
        check_eq("t1_plot_lag", plot, 1'b0);
        bad = 0;
        for (int i = 0; i < 19359; i++) begin
            step();
            if (!drStage1 || !plot || colour_sel) bad++;
        end
        check_eq("t1_stage_hold", bad, 0);
        check_eq("t1_vga_bkg", {vga_x, vga_y}, {8'h55, 7'h3C});
        pulse_done();
        check_eq("t1_gap_cmds", {drStage1, erM, drM}, 3'b000);
        check_eq("t1_gap_plot", plot, 1'b0);
        step();
        check_eq("t1_draw", {drM, px, py}, {1'b1, 16'h0000});
        check_eq("t1_draw_plot0", plot, 1'b0);
        step();
        check_eq("t1_draw_plot1", {plot, colour_sel}, 2'b11);
        check_eq("t1_vga_spr", {vga_x, vga_y}, {8'hAA, 7'h43});
        pulse_done();
        check_eq("t1_fin", {frame_done, drM, plot}, 3'b100);
        step();
        check_eq("t1_idle", {frame_done, busy}, 2'b00);

        // 2: move to (30,40)
        pos_x = 8'd30; pos_y = 8'd40; frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check_eq("t2_erase", {erM, drM, drStage1, plot, overrun}, 5'b10000);
        check_eq("t2_px_held", {px, py}, 16'h0000);
        step();
        check_eq("t2_erase_plot", {plot, colour_sel}, 2'b10);
        pulse_done();
        check_eq("t2_gap_pos", {px, py}, {8'd30, 8'd40});
        check_eq("t2_gap_low", {erM, drM, plot}, 3'b000);
        step();
        check_eq("t2_draw_gapplot", {drM, plot}, 2'b10);
        step();
        check_eq("t2_draw_plot", {plot, colour_sel}, 2'b11);
        pulse_done();
        check_eq("t2_fin", {frame_done, plot}, 2'b10);
        step();

        // 3: clamping, then unchanged position
        pos_x = 8'd200; pos_y = 8'd250; frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check_eq("t3_erase", erM, 1'b1);
        pulse_done();
        check_eq("t3_clamp", {px, py}, {8'd148, 8'd104});
        step();
        pulse_done();
        check_eq("t3_fin1", frame_done, 1'b1);
        step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check_eq("t3_same_fin", {frame_done, drStage1, erM, drM}, 4'b1000);
        step();
        check_eq("t3_same_idle", {frame_done, busy}, 2'b00);

        // 4: tick + stage_req together, tick during DRAW
        pos_x = 8'd10; pos_y = 8'd10; frame_tick = 1'b1; stage_req = 1'b1;
        step();
        frame_tick = 1'b0; stage_req = 1'b0;
        check_eq("t4_stage_wins", {drStage1, erM}, 2'b10);
        step();
        pulse_done();
        check_eq("t4_px_kept", {px, py}, {8'd148, 8'd104});
        step();
        check_eq("t4_draw", drM, 1'b1);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check_eq("t4_overrun", {overrun, drM}, 2'b11);
        step();
        check_eq("t4_overrun_off", overrun, 1'b0);
        pulse_done();
        check_eq("t4_fin", frame_done, 1'b1);
        step();
        step();
        check_eq("t4_no_extra", {busy, frame_done, erM, drStage1}, 4'b0000);

        // 5: stage_req during ERASE is deferred to the next IDLE
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check_eq("t5_erase", erM, 1'b1);
        stage_req = 1'b1;
        step();
        stage_req = 1'b0;
        check_eq("t5_erase_kept", {erM, drStage1}, 2'b10);
        pulse_done();
        check_eq("t5_gap_pos", {px, py}, {8'd10, 8'd10});
        step();
        pulse_done();
        check_eq("t5_fin", frame_done, 1'b1);
        step();
        check_eq("t5_idle", {busy, drStage1}, 2'b00);
        step();
        check_eq("t5_stage", drStage1, 1'b1);
        step();
        pulse_done();
        step();
        pulse_done();
        step();
        check_eq("t5_back_idle", busy, 1'b0);

        // 6: watchdog
        pos_x = 8'd50; pos_y = 8'd60; frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        bad = 0;
        for (int i = 0; i < TMO - 1; i++) begin
            if (!erM || timeout_err) bad++;
            step();
        end
        check_eq("t6_hold", bad, 0);
        check_eq("t6_last_cycle", {erM, timeout_err}, 2'b10);
        step();
        check_eq("t6_abort", {erM, busy, timeout_err, frame_done}, 4'b0010);
        step();
        check_eq("t6_sticky", {timeout_err, frame_done, px, py}, {2'b10, 8'd10, 8'd10});
        pulse_done();
        check_eq("t6_done_ignored", {busy, drStage1, erM, drM}, 4'b0000);
        reset = 1'b1;
        step();
        check_eq("t6_reset_clr", {timeout_err, px, py}, {1'b0, 16'h0000});
        reset = 1'b0;
        step();
        check_eq("t6_reboot", drStage1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
